// File: rtl/d_tile_miss_queue.sv
`default_nettype none
// ============================================================================
// d_tile_miss_queue : D-tile L1 read-miss / writeback queue toward NUCA L2
// Revision 1.0
// ============================================================================
module d_tile_miss_queue #(
  parameter int DEPTH      = 4,
  parameter int LINE_BEATS = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dt_read_req,
  input  logic                          dt_write_req,
  input  logic [ADDR_WIDTH-1:0]         dt_addr,
  input  logic [63:0]                   dt_wb_data,
  output logic                          dt_req_ready,
  output logic                          net_req_valid,
  input  logic                          net_req_ready,
  output logic                          net_req_write,
  output logic [ADDR_WIDTH-1:0]         net_req_addr,
  output logic [63:0]                   net_req_data,
  input  logic                          net_rsp_valid,
  input  logic [63:0]                   net_rsp_data,
  output logic                          fill_valid,
  output logic [ADDR_WIDTH-1:0]         fill_addr,
  output logic [$clog2(LINE_BEATS)-1:0] fill_beat,
  output logic [63:0]                   fill_data,
  output logic                          fill_last,
  output logic                          busy,
  output logic                          err_unexpected
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam int OFS    = 6;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_FILL} state_t;

  state_t                  state;
  logic                    q_write [DEPTH];
  logic [ADDR_WIDTH-1:0]   q_addr  [DEPTH];
  logic [63:0]             q_data  [DEPTH];
  logic [PTR_W-1:0]        rd_ptr, wr_ptr, rd_slot, offs;
  logic [CNT_W-1:0]        count, n_push;
  logic [BEAT_W-1:0]       beat_cnt;
  logic                    read_hit, push_wr, push_rd, pop, issuing, rsp_take;
  logic                    drop_stale;

  assign dt_req_ready = (count <= CNT_W'(DEPTH - 2));

  always_comb begin
    read_hit = (state == WAIT_FILL) &&
               (fill_addr[ADDR_WIDTH-1:OFS] == dt_addr[ADDR_WIDTH-1:OFS]);
    offs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr;
      if ((CNT_W'(offs) < count) && !q_write[i] &&
          (q_addr[i][ADDR_WIDTH-1:OFS] == dt_addr[ADDR_WIDTH-1:OFS]))
        read_hit = 1'b1;
    end
  end

  assign push_wr = dt_req_ready && dt_write_req;
  assign push_rd = dt_req_ready && dt_read_req && !read_hit;
  assign n_push  = CNT_W'(push_wr) + CNT_W'(push_rd);
  assign rd_slot = push_wr ? wr_ptr + PTR_W'(1) : wr_ptr;
  assign issuing = (state == ISSUE);
  assign pop     = issuing && net_req_ready;

  // Entry storage carries no reset; validity is tracked purely by count.
  always_ff @(posedge clk) begin
    if (push_wr) begin
      q_write[wr_ptr] <= 1'b1;
      q_addr[wr_ptr]  <= dt_addr;
      q_data[wr_ptr]  <= dt_wb_data;
    end
    if (push_rd) begin
      q_write[rd_slot] <= 1'b0;
      q_addr[rd_slot]  <= {dt_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
      q_data[rd_slot]  <= 64'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + n_push - CNT_W'(pop);
    end
  end

  // Beats seen right after reset belong to an aborted fill; drop them silently
  // until the network goes quiet for one cycle.
  assign rsp_take = (state == WAIT_FILL) && net_rsp_valid && !drop_stale;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      beat_cnt       <= '0;
      fill_addr      <= '0;
      err_unexpected <= 1'b0;
      drop_stale     <= 1'b1;
    end else begin
      if (!net_rsp_valid) drop_stale <= 1'b0;
      if (net_rsp_valid && (state != WAIT_FILL) && !drop_stale)
        err_unexpected <= 1'b1;
      case (state)
        IDLE: begin
          if (count != '0) state <= ISSUE;
        end
        ISSUE: begin
          if (net_req_ready) begin
            if (q_write[rd_ptr]) begin
              state <= IDLE;
            end else begin
              state     <= WAIT_FILL;
              fill_addr <= q_addr[rd_ptr];
              beat_cnt  <= '0;
            end
          end
        end
        WAIT_FILL: begin
          if (rsp_take) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign net_req_valid = issuing;
  assign net_req_write = issuing && q_write[rd_ptr];
  assign net_req_addr  = issuing ? q_addr[rd_ptr] : '0;
  assign net_req_data  = (issuing && q_write[rd_ptr]) ? q_data[rd_ptr] : 64'h0;

  assign fill_valid = rsp_take;
  assign fill_beat  = beat_cnt;
  assign fill_data  = rsp_take ? net_rsp_data : 64'h0;
  assign fill_last  = rsp_take && (beat_cnt == LAST_BEAT);

  assign busy = (count != '0) || (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_d_tile_miss_queue.sv
`default_nettype none
// tb_d_tile_miss_queue : scoreboard bench; directed stimulus queues expected
// network requests and fill beats, a negedge monitor pops and compares them.
module tb_d_tile_miss_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dt_read_req = 1'b0, dt_write_req = 1'b0;
  logic [31:0] dt_addr = '0;
  logic [63:0] dt_wb_data = '0;
  logic        dt_req_ready;
  logic        net_req_valid, net_req_ready = 1'b0, net_req_write;
  logic [31:0] net_req_addr;
  logic [63:0] net_req_data;
  logic        net_rsp_valid = 1'b0;
  logic [63:0] net_rsp_data = '0;
  logic        fill_valid, fill_last, busy, err_unexpected;
  logic [31:0] fill_addr;
  logic [2:0]  fill_beat;
  logic [63:0] fill_data;

  always #5 clk = ~clk;

  d_tile_miss_queue dut (
    .clk(clk), .rst(rst),
    .dt_read_req(dt_read_req), .dt_write_req(dt_write_req),
    .dt_addr(dt_addr), .dt_wb_data(dt_wb_data), .dt_req_ready(dt_req_ready),
    .net_req_valid(net_req_valid), .net_req_ready(net_req_ready),
    .net_req_write(net_req_write), .net_req_addr(net_req_addr),
    .net_req_data(net_req_data),
    .net_rsp_valid(net_rsp_valid), .net_rsp_data(net_rsp_data),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_beat(fill_beat),
    .fill_data(fill_data), .fill_last(fill_last),
    .busy(busy), .err_unexpected(err_unexpected)
  );

  typedef struct packed {logic write; logic [31:0] addr; logic [63:0] data;} req_t;
  typedef struct packed {logic [31:0] addr; logic [2:0] beat; logic [63:0] data; logic last;} beat_t;

  req_t  exp_req[$];
  beat_t exp_fill[$];
  int    vectors = 0;
  int    miscompares = 0;

  function automatic req_t mk_req(input logic w, input logic [31:0] a, input logic [63:0] d);
    req_t r;
    r.write = w; r.addr = a; r.data = d;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every DUT handshake / fill beat must match the next expectation.
  always @(negedge clk) begin
    req_t  er;
    beat_t eb;
    if (net_req_valid && net_req_ready) begin
      if (exp_req.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL net_req_unexpected: got addr 0x%0h expected no request", net_req_addr);
      end else begin
        er = exp_req.pop_front();
        chk("net_req_write", net_req_write, er.write);
        chk("net_req_addr",  net_req_addr,  er.addr);
        chk("net_req_data",  net_req_data,  er.data);
      end
    end
    if (fill_valid) begin
      if (exp_fill.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL fill_unexpected: got beat %0d expected no fill", fill_beat);
      end else begin
        eb = exp_fill.pop_front();
        chk("fill_addr", fill_addr, eb.addr);
        chk("fill_beat", fill_beat, eb.beat);
        chk("fill_data", fill_data, eb.data);
        chk("fill_last", fill_last, eb.last);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic enq(input logic rd, input logic wr, input logic [31:0] a, input logic [63:0] d);
    dt_read_req = rd; dt_write_req = wr; dt_addr = a; dt_wb_data = d;
    step();
    dt_read_req = 1'b0; dt_write_req = 1'b0;
  endtask

  task automatic wait_issue(input string name);
    int n;
    n = 0;
    while (!(net_req_valid && net_req_ready) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: got no handshake in 50 cycles expected one", name);
    end
    step();
  endtask

  task automatic send_fill(input logic [31:0] line, input int nbeats);
    beat_t       eb;
    logic [63:0] d;
    for (int b = 0; b < nbeats; b++) begin
      d = {32'hF111_0000 | 32'(b), line};
      eb.addr = line; eb.beat = 3'(b); eb.data = d; eb.last = (b == 7);
      exp_fill.push_back(eb);
      net_rsp_valid = 1'b1;
      net_rsp_data  = d;
      chk("no_req_during_fill", net_req_valid, 1'b0);
      step();
    end
    net_rsp_valid = 1'b0;
    net_rsp_data  = '0;
  endtask

  task automatic hold_chk();
    chk("hold_valid", net_req_valid, 1'b1);
    chk("hold_write", net_req_write, 1'b0);
    chk("hold_addr",  net_req_addr,  32'h300);
    chk("hold_data",  net_req_data,  64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset();
    chk("rst_dt_req_ready", dt_req_ready, 1'b1);
    chk("rst_net_req_valid", net_req_valid, 1'b0);
    chk("rst_net_req_addr", net_req_addr, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fill_valid", fill_valid, 1'b0);
    chk("rst_fill_last", fill_last, 1'b0);
    chk("rst_err", err_unexpected, 1'b0);

    // Single read: line-aligned request, 2-cycle latency, 8-beat fill
    net_req_ready = 1'b1;
    exp_req.push_back(mk_req(1'b0, 32'h0000_1200, 64'h0));
    enq(1'b1, 1'b0, 32'h0000_1234, 64'h0);
    chk("t1_latency_c1", net_req_valid, 1'b0);
    step();
    chk("t1_latency_c2", net_req_valid, 1'b1);
    wait_issue("t1");
    send_fill(32'h0000_1200, 8);
    chk("t1_busy_done", busy, 1'b0);

    // Duplicate read to the same line merges
    exp_req.push_back(mk_req(1'b0, 32'h40, 64'h0));
    enq(1'b1, 1'b0, 32'h40, 64'h0);
    enq(1'b1, 1'b0, 32'h7C, 64'h0);
    chk("t2_busy", busy, 1'b1);
    wait_issue("t2");
    send_fill(32'h40, 8);
    chk("t2_busy_done", busy, 1'b0);

    // Simultaneous write + read: write goes first
    exp_req.push_back(mk_req(1'b1, 32'h108, 64'hDEAD));
    exp_req.push_back(mk_req(1'b0, 32'h100, 64'h0));
    enq(1'b1, 1'b1, 32'h108, 64'hDEAD);
    wait_issue("t3_wr");
    wait_issue("t3_rd");
    send_fill(32'h100, 8);
    chk("t3_busy_done", busy, 1'b0);

    // Backpressure: head held stable, queue fills, ready drops
    net_req_ready = 1'b0;
    exp_req.push_back(mk_req(1'b0, 32'h300, 64'h0));
    enq(1'b1, 1'b0, 32'h300, 64'h0);
    n = 0;
    while (!net_req_valid && n < 20) begin step(); n++; end
    chk("t4_valid_seen", net_req_valid, 1'b1);
    exp_req.push_back(mk_req(1'b1, 32'h400, 64'h11));
    enq(1'b0, 1'b1, 32'h400, 64'h11);
    hold_chk();
    chk("t4_ready_2free", dt_req_ready, 1'b1);
    exp_req.push_back(mk_req(1'b1, 32'h540, 64'h22));
    exp_req.push_back(mk_req(1'b0, 32'h540, 64'h0));
    enq(1'b1, 1'b1, 32'h540, 64'h22);
    hold_chk();
    chk("t4_ready_full", dt_req_ready, 1'b0);
    enq(1'b1, 1'b0, 32'h700, 64'h0);
    hold_chk();
    step();
    hold_chk();
    step();
    hold_chk();
    net_req_ready = 1'b1;
    wait_issue("t4_rd300");
    send_fill(32'h300, 8);
    wait_issue("t4_wr400");
    wait_issue("t4_wr540");
    wait_issue("t4_rd540");
    send_fill(32'h540, 8);
    chk("t4_busy_done", busy, 1'b0);

    // Response beat with nothing outstanding
    chk("t5_err_before", err_unexpected, 1'b0);
    net_rsp_valid = 1'b1;
    net_rsp_data  = 64'hBAD;
    chk("t5_no_fill", fill_valid, 1'b0);
    step();
    net_rsp_valid = 1'b0;
    chk("t5_err_set", err_unexpected, 1'b1);
    step();
    step();
    chk("t5_err_sticky", err_unexpected, 1'b1);

    // Reset after beat 3: queue cleared, trailing beats dropped without error
    do_reset();
    chk("t6_err_cleared", err_unexpected, 1'b0);
    exp_req.push_back(mk_req(1'b0, 32'h800, 64'h0));
    enq(1'b1, 1'b0, 32'h800, 64'h0);
    wait_issue("t6");
    send_fill(32'h800, 4);
    net_rsp_valid = 1'b1;
    net_rsp_data  = 64'h5;
    rst = 1'b1;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_fill_valid", fill_valid, 1'b0);
    chk("t6_ready", dt_req_ready, 1'b1);
    step();
    step();
    rst = 1'b0;
    step();
    chk("t6_fill_valid_post", fill_valid, 1'b0);
    step();
    net_rsp_valid = 1'b0;
    step();
    chk("t6_err_clear", err_unexpected, 1'b0);
    chk("t6_busy_post", busy, 1'b0);

    // Normal operation resumes after the aborted fill
    exp_req.push_back(mk_req(1'b0, 32'hA40, 64'h0));
    enq(1'b1, 1'b0, 32'hA55, 64'h0);
    wait_issue("t7");
    send_fill(32'hA40, 8);
    chk("t7_busy_done", busy, 1'b0);
    chk("t7_err", err_unexpected, 1'b0);

    step();
    chk("exp_req_drained", exp_req.size(), 0);
    chk("exp_fill_drained", exp_fill.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
